btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//   Conditions N_CH raw asynchronous board inputs (switches/push-buttons) into clean,
//   debounced, clk-synchronous levels plus one-cycle rise/fall pulses. This is the
//   producing end of the 3-input logic block's in_1..in_3 pins.
//   Sits between FPGA input pads and all console logic. All outputs are registered.
// PARAMETERS
//   N_CH             3   number of independent input channels
//   DEBOUNCE_CYCLES  16  stable sync-domain cycles required before a level is accepted; legal range >= 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES)  counter width; derived, do not override
// PORTS
//   clk          in   1     system clock, rising-edge
//   rst_n        in   1     asynchronous, active-low reset
//   raw_in       in   N_CH  raw pad inputs, asynchronous to clk
//   clean_out    out  N_CH  debounced level per channel
//   rise_pulse   out  N_CH  1-cycle pulse when clean_out[i] goes 0->1
//   fall_pulse   out  N_CH  1-cycle pulse when clean_out[i] goes 1->0
//   press_count  out  8     rising edges seen on channel 0 (only with PRESS_COUNT_EN)
// BEHAVIOUR
//   Reset: one clock and one reset only; rst_n low clears everything immediately,
//     regardless of clk. This covers both sync flops, all counters, clean_out, rise_pulse,
//     fall_pulse and press_count, which are all 0 during reset.
//   Sync: each channel passes through a 2-flop synchronizer: sync1 <= raw_in; sync2 <= sync1.
//   Per-channel counter cnt[i] is CNT_W bits wide. At each clk edge:
//     sync2 == clean_out             -> cnt <= 0 (glitch rejected, no output change)
//     differs, cnt <  DEBOUNCE_CYCLES-1 -> cnt <= cnt+1
//     differs, cnt == DEBOUNCE_CYCLES-1 -> clean_out <= sync2; cnt <= 0
//   Latency: raw_in changes before edge k and stays stable -> clean_out updates on edge
//     k+DEBOUNCE_CYCLES+1.
//   Glitch rejection: a level that returns before completing the count restarts the count
//     from 0 on the next differing cycle. There is no partial credit.
//   Pulses: rise_pulse[i]/fall_pulse[i] are registered. They are asserted on the same edge
//     that clean_out[i] flips and are high for exactly one cycle.
//     Rise and fall are never both high on one channel. Channels are fully independent, so
//     simultaneous flips on several channels give simultaneous pulses.
//   Reset release with raw_in high: this is treated as a real 0->1 transition; clean_out
//     rises DEBOUNCE_CYCLES+1 edges after the first sampling edge, with a rise_pulse.
//   Reset mid-debounce: the pending count is discarded, and the count restarts after
//     rst_n deasserts.
//   Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
// CONFIGURATION
//   PRESS_COUNT_EN defined:
//     press_count port exists; 8-bit register, +1 on every rise_pulse[0] cycle.
//     Wraps 255->0; reset value 0.
//   PRESS_COUNT_EN undefined:
//     press_count port and its register are absent; all other behaviour identical.
// TESTING  (DEBOUNCE_CYCLES=4, N_CH=3, clk period 10)
//   1 Reset with raw_in=3'b101, release at edge 0 -> clean_out=000 through edge 4;
//     clean_out=101 after edge 5; rise_pulse=101 for exactly that cycle.
//   2 raw_in[1] 0->1 held -> clean_out[1]=1 exactly 5 edges later; single rise_pulse[1];
//     fall_pulse=000 throughout.
//   3 raw_in[0] glitch high for 2 cycles, then low -> clean_out and pulses stay 0;
//     cnt[0] returns to 0.
//   4 Bouncing raw_in[2] (1,0,1,1,1,1,...) -> one rise after the final stable run of 4;
//     exactly one rise_pulse[2].
//   5 rst_n pulsed low mid-count (cnt=2) asynchronously between edges -> outputs 0
//     immediately; the count restarts from 0 after release.
//   6 PRESS_COUNT_EN: 257 debounced presses on ch0 -> press_count=1 (wrap).
//     Without the macro, the bench compiles without the port.

Source files
------------

// File: rtl/btn_debounce.sv
// Purpose : debounce N_CH asynchronous pad inputs into clk-synchronous levels with 1-cycle rise/fall pulses.
// Latency : a raw change held stable appears on clean_out DEBOUNCE_CYCLES+2 edges after the change (counting its first sampling edge).
// Backpress: none; free-running input conditioner, outputs are always valid.
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset, clears every flop
//   raw_in       raw pad inputs, asynchronous to clk
//   clean_out    debounced level per channel (registered)
//   rise_pulse   one-cycle pulse on the edge clean_out[i] goes 0->1 (registered)
//   fall_pulse   one-cycle pulse on the edge clean_out[i] goes 1->0 (registered)
//   press_count  8-bit wrapping count of channel-0 rises; present only when
//                PRESS_COUNT_EN is defined
//
// Build option: define PRESS_COUNT_EN to add the press_count port and register.
module btn_debounce #(
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
`ifdef PRESS_COUNT_EN
  ,
  output logic [7:0]      press_count
`endif
);

  // Counter width is derived; DEBOUNCE_CYCLES >= 2 keeps it at least 1 bit.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]  sync1_q, sync2_q;
  logic [N_CH-1:0]  clean_q, clean_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // Two-flop synchronizer; raw_in is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel stability counter. Any cycle where the synchronized input
  // agrees with the accepted level throws the partial count away, so only an
  // unbroken run of DEBOUNCE_CYCLES differing cycles moves clean_out.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef PRESS_COUNT_EN
  logic [7:0] press_q, press_d;

  // Counts on the same edge that raises rise_pulse[0], so the count and the
  // pulse become visible together. Wraps naturally at 8 bits.
  always_comb begin
    press_d = press_q;
    if (rise_d[0]) begin
      press_d = press_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q <= '0;
    end else begin
      press_q <= press_d;
    end
  end

  assign press_count = press_q;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Purpose : self-checking bench for btn_debounce (N_CH=3, DEBOUNCE_CYCLES=4) with a history-based reference model.
// Latency : model predicts each clean_out flip edge; monitor compares pulses against queued predictions one per event.
// Backpress: none; stimulus and monitor run freely off the clock.
module tb_btn_debounce;

  localparam int N = 3;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] raw_in;
  logic [N-1:0] clean_out;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
`ifdef PRESS_COUNT_EN
  logic [7:0]   press_count;
`endif

  btn_debounce #(.N_CH(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
`ifdef PRESS_COUNT_EN
    ,
    .press_count(press_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model keeps every raw sample since reset release. The synchronized
  // value seen at edge t is the raw sample from edge t-2 (0 before that).
  // A channel flips at edge e when the last D evaluated samples all differ
  // from the accepted level and none of them precede the previous flip.
  typedef struct {
    int           en;
    logic [N-1:0] r;
    logic [N-1:0] f;
  } ev_t;

  ev_t          exp_q[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] clean_m = '0;
  int           last_flip[N] = '{-1, -1, -1};
  int           e = 0;
  logic [7:0]   presses_m = '0;

  function automatic logic [N-1:0] sv_at(input int t);
    return (t >= 2) ? hist[t-2] : '0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        hist.delete();
        clean_m   = '0;
        e         = 0;
        presses_m = '0;
        for (int c = 0; c < N; c++) last_flip[c] = -1;
      end else begin
        logic [N-1:0] r, f;
        r = '0;
        f = '0;
        hist.push_back(raw_in);
        for (int c = 0; c < N; c++) begin
          bit ok;
          logic [N-1:0] s;
          ok = 1'b1;
          for (int j = 0; j < D; j++) begin
            int t;
            t = e - j;
            s = sv_at(t);
            if (t < 0 || t <= last_flip[c] || s[c] == clean_m[c]) ok = 1'b0;
          end
          if (ok) begin
            clean_m[c]   = ~clean_m[c];
            last_flip[c] = e;
            if (clean_m[c]) r[c] = 1'b1;
            else            f[c] = 1'b1;
          end
        end
        if ((r | f) != '0) exp_q.push_back('{en: e, r: r, f: f});
        if (r[0]) presses_m = presses_m + 8'd1;
        e++;
      end
    end
  end

  // ---------------- monitor ----------------
  int rise_seen[N] = '{0, 0, 0};

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_clean", 32'(clean_out), 32'(0));
        chk("reset_pulses", 32'({rise_pulse, fall_pulse}), 32'(0));
      end else begin
        chk("clean_level", 32'(clean_out), 32'(clean_m));
`ifdef PRESS_COUNT_EN
        chk("press_count", 32'(press_count), 32'(presses_m));
`endif
        for (int c = 0; c < N; c++) if (rise_pulse[c]) rise_seen[c]++;
        if ((rise_pulse | fall_pulse) != '0 || exp_q.size() != 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'({rise_pulse, fall_pulse}), 32'(0));
          end else begin
            ev_t ev;
            ev = exp_q.pop_front();
            chk("rise_pulse", 32'(rise_pulse), 32'(ev.r));
            chk("fall_pulse", 32'(fall_pulse), 32'(ev.f));
            chk("both_pulse", 32'(rise_pulse & fall_pulse), 32'(0));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r2;
    rst_n  = 1'b0;
    raw_in = 3'b101;
    cyc(3);

    // 1: release with raw_in=101 -> flip after edge 5
    rst_n = 1'b1;
    cyc(5);
    chk("t1_clean_edge4", 32'(clean_out), 32'(3'b000));
    cyc(1);
    chk("t1_clean_edge5", 32'(clean_out), 32'(3'b101));
    chk("t1_rise_edge5", 32'(rise_pulse), 32'(3'b101));
    cyc(1);
    chk("t1_rise_gone", 32'(rise_pulse), 32'(3'b000));

    // 2: channel 1 rises exactly 5 edges later
    raw_in[1] = 1'b1;
    cyc(5);
    chk("t2_clean1_edge4", 32'(clean_out[1]), 32'(0));
    cyc(1);
    chk("t2_clean1_edge5", 32'(clean_out[1]), 32'(1));
    chk("t2_rise", 32'(rise_pulse), 32'(3'b010));
    cyc(4);

    // 3: 2-cycle glitch on channel 0 is rejected
    raw_in = 3'b000;
    cyc(10);
    r2 = rise_seen[0];
    raw_in[0] = 1'b1;
    cyc(2);
    raw_in[0] = 1'b0;
    cyc(10);
    chk("t3_clean0", 32'(clean_out[0]), 32'(0));
    chk("t3_no_rise", 32'(rise_seen[0] - r2), 32'(0));

    // 4: bouncing channel 2 gives one rise
    r2 = rise_seen[2];
    raw_in[2] = 1'b1; cyc(1);
    raw_in[2] = 1'b0; cyc(1);
    raw_in[2] = 1'b1; cyc(10);
    chk("t4_clean2", 32'(clean_out[2]), 32'(1));
    chk("t4_one_rise", 32'(rise_seen[2] - r2), 32'(1));

    // 5: async reset mid-count on channel 0
    raw_in[0] = 1'b1;
    cyc(4);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_clean_now", 32'(clean_out), 32'(0));
    chk("t5_pulses_now", 32'({rise_pulse, fall_pulse}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5);
    chk("t5_clean_edge4", 32'(clean_out), 32'(3'b000));
    cyc(1);
    chk("t5_clean_edge5", 32'(clean_out), 32'(3'b101));

    // random bouncing on all channels
    for (int i = 0; i < 300; i++) begin
      raw_in = raw_in ^ 3'($urandom_range(0, 7));
      cyc($urandom_range(1, 7));
    end
    cyc(10);

`ifdef PRESS_COUNT_EN
    // 6: 257 presses wrap the counter to 1
    raw_in = '0;
    rst_n  = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 257; i++) begin
      raw_in[0] = 1'b1; cyc(7);
      raw_in[0] = 1'b0; cyc(7);
    end
    chk("t6_press_wrap", 32'(press_count), 32'(8'd1));
`endif

    cyc(2);
    chk("events_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
